instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Upstream neighbour of the main decoder in the RISC-V core: owns the program counter, issues word fetches to instruction memory over a valid/ready request channel, and buffers the returned instructions. Each buffered instruction is handed to decode with its PC over a valid/ready handshake; `instr[6:0]` drives the decoder opcode input. Branch/jump redirects from execute flush all buffered and in-flight fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset
- `XLEN`, 32, address/PC width
- `BUF_DEPTH`, 2, instruction buffer entries (power of two, ≥2)

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `imem_req_valid`  out  1  fetch request present
- `imem_req_addr`  out  XLEN  byte address of fetch, bits [1:0] always 0
- `imem_req_ready`  in  1  memory accepts request this cycle
- `imem_rsp_valid`  in  1  instruction word returned (always accepted)
- `imem_rsp_data`  in  32  returned instruction word
- `instr_valid`  out  1  buffer head valid toward decode
- `instr`  out  32  head instruction
- `instr_pc`  out  XLEN  PC of head instruction
- `instr_ready`  in  1  decode consumes head this cycle
- `redirect_valid`  in  1  flush and restart fetch
- `redirect_pc`  in  XLEN  new fetch PC; bits [1:0] ignored (forced 0)

## Operation
- Registers: `fetch_pc`, `inflight_pc`, FSM state, buffer (instr + pc per entry), occupancy count.
- At most one request outstanding. Request issued only when occupancy + outstanding < BUF_DEPTH.
- FSM states:
  - IDLE: `imem_req_valid` = credit available. On valid&&ready: `inflight_pc`←`fetch_pc`, `fetch_pc`←`fetch_pc`+4 (mod 2^XLEN wrap), → WAIT.
  - WAIT: on `imem_rsp_valid`: push {data, `inflight_pc`}, → IDLE.
  - DRAIN: on `imem_rsp_valid`: discard data, → IDLE.
- Redirect (highest priority, any state): buffer flushed (occupancy 0, `instr_valid` low next cycle), `fetch_pc`←{`redirect_pc`[XLEN-1:2],2'b00}. IDLE→IDLE (no request issued that cycle); WAIT→DRAIN; DRAIN stays DRAIN. A response arriving in the redirect cycle is discarded and ends the outstanding request (WAIT/DRAIN→IDLE).
- Redirect same cycle as `instr_ready`: redirect wins; pop is void.
- Push and pop same cycle: both take effect, occupancy unchanged.
- `imem_rsp_valid` in IDLE (no outstanding) is ignored.
- Once asserted, `imem_req_valid`/`imem_req_addr` held stable until ready, except on redirect.
- Buffer ordering strictly FIFO; pointers wrap modulo BUF_DEPTH.

## Timing
- Reset: `fetch_pc`=RESET_PC, state IDLE, occupancy 0; `imem_req_valid`=0 and `instr_valid`=0 in reset cycle; `imem_req_addr`=RESET_PC, `instr`=32'h0000_0013 (NOP), `instr_pc`=0 when buffer empty.
- First request: `imem_req_valid`=1 in first cycle after `rst` deasserts.
- Response at cycle N → `instr_valid`=1 at N+1.
- Request issue to decode visible: 1 + memory latency + 1 cycles minimum.
- Steady-state throughput: one instruction per 2 cycles with 1-cycle memory.
- Redirect at cycle N → first request to `redirect_pc` at N+1 if IDLE, else the cycle after the discarded response.
- `rst` mid-transaction: all state reset; a later response to the pre-reset request is ignored.

## Structure
- Shared package `riscv_pkg`: XLEN, RESET_PC default, NOP encoding 32'h0000_0013, opcode constants (lw, sw, branch, I-type) shared with the decoder, fetch FSM state enum (IDLE, WAIT, DRAIN).
- One sub-module: `fetch_buffer` — synchronous FIFO of {instr, pc}, BUF_DEPTH entries, push/pop/flush, count output.

## Test plan
- Reset release, 1-cycle memory returning 32'h0000_0013 per address: requests 0x0, 0x4, 0x8…; decode sees same PCs in order, one every 2 cycles.
- `instr_ready`=0 for 10 cycles: exactly BUF_DEPTH instructions buffered, no further `imem_req_valid`; raising ready resumes at next sequential PC with no gap or duplicate.
- Redirect to 0x100 while request to 0x8 outstanding: 0x8 response discarded, next request 0x100, first decoded `instr_pc`=0x100.
- `redirect_pc`=0x103 with simultaneous `instr_ready` and `imem_rsp_valid`: buffer empty next cycle, response dropped, next request 0x100.
- `imem_req_ready` held low 5 cycles: address stable throughout; PC 0xFFFF_FFFC fetched then wraps to 0x0.
- `rst` asserted while WAIT: next request RESET_PC; stale response after reset produces no `instr_valid`.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: widths, reset PC, NOP encoding, base opcodes
// and the instruction-fetch FSM state type.
package riscv_pkg;

    localparam int unsigned XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDrain
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetched {instr, pc} pairs with flush; presents a NOP at
// PC 0 whenever it is empty.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned PcW   = XLEN,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = $clog2(Depth) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic [31:0]     instr_i,
    input  logic [PcW-1:0]  pc_i,
    input  logic            pop_i,
    output logic [31:0]     instr_o,
    output logic [PcW-1:0]  pc_o,
    output logic [CntW-1:0] count_o
);

    logic [31:0]     instr_mem [Depth];
    logic [PcW-1:0]  pc_mem    [Depth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            instr_mem[wr_ptr_q] <= instr_i;
            pc_mem[wr_ptr_q]    <= pc_i;
        end
    end

    always_comb begin
        instr_o = NOP_INSTR;
        pc_o    = '0;
        if (count_q != '0) begin
            instr_o = instr_mem[rd_ptr_q];
            pc_o    = pc_mem[rd_ptr_q];
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues one outstanding word fetch at a time and
// buffers returned instructions for decode; redirects flush everything.
module instr_fetch_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(riscv_pkg::RESET_PC_DEFAULT),
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    import riscv_pkg::*;

    localparam int unsigned     CntW    = $clog2(BUF_DEPTH) + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(BUF_DEPTH);

    fetch_state_e    state_q;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] inflight_pc_q;
    logic [CntW-1:0] count;
    logic            buf_valid;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic            unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Requests only leave IDLE, so "no outstanding" is implied; the credit check
    // then reduces to free buffer space.
    assign buf_valid      = (count != '0);
    assign imem_req_valid = !rst && !redirect_valid && (state_q == StIdle) && (count < FullCnt);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign push           = !rst && !redirect_valid && (state_q == StWait) && imem_rsp_valid;
    assign pop            = !rst && !redirect_valid && buf_valid && instr_ready;
    assign instr_valid    = !rst && buf_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
        end else if (redirect_valid) begin
            fetch_pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
            // A response landing in the redirect cycle closes the old request.
            if ((state_q != StIdle) && !imem_rsp_valid) begin
                state_q <= StDrain;
            end else begin
                state_q <= StIdle;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_fire) begin
                        inflight_pc_q <= fetch_pc_q;
                        fetch_pc_q    <= fetch_pc_q + XLEN'(4);
                        state_q       <= StWait;
                    end
                end
                StWait: begin
                    if (imem_rsp_valid) begin
                        state_q <= StIdle;
                    end
                end
                StDrain: begin
                    if (imem_rsp_valid) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    fetch_buffer #(
        .Depth (BUF_DEPTH),
        .PcW   (XLEN)
    ) u_fetch_buffer (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid),
        .push_i  (push),
        .instr_i (imem_rsp_data),
        .pc_i    (inflight_pc_q),
        .pop_i   (pop),
        .instr_o (instr),
        .pc_o    (instr_pc),
        .count_o (count)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized bench for instr_fetch_unit against a transaction-level
// model (queue of expected decode entries, next fetch PC, one outstanding slot).
module tb_instr_fetch_unit;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .XLEN      (XLEN),
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model
    logic [63:0] mq[$];
    logic [31:0] m_pc = RST_PC;
    bit          m_out = 0;
    bit          m_stale = 0;
    logic [31:0] m_out_pc = '0;

    // Memory model, independent of DUT reset
    bit          mem_busy = 0;
    logic [31:0] mem_addr = '0;
    int          mem_cnt = 0;

    // Per-cycle controls and observations
    bit          c_rst = 1;
    bit          c_redir = 0;
    logic [31:0] c_rpc = '0;
    int          c_rdy_pct = 100;
    int          c_mem_pct = 100;
    int          c_lat_max = 1;
    int          cyc = 0;
    bit          obs_req_valid, obs_iv, obs_pop;
    logic [31:0] obs_addr, obs_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        bit          exp_req, exp_iv, fire, pop, rsp;
        logic [63:0] head;
        @(negedge clk);
        cyc++;
        rsp            = mem_busy && (mem_cnt == 0);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(mem_addr) : $urandom;
        rst            = c_rst;
        redirect_valid = c_redir;
        redirect_pc    = c_redir ? c_rpc : $urandom;
        instr_ready    = ($urandom_range(99) < c_rdy_pct);
        imem_req_ready = !mem_busy && ($urandom_range(99) < c_mem_pct);
        #1;
        obs_req_valid = imem_req_valid;
        obs_addr      = imem_req_addr;
        obs_iv        = instr_valid;
        obs_pc        = instr_pc;
        obs_pop       = instr_valid && instr_ready && !c_redir;

        exp_req = !c_rst && !c_redir && !m_out && (mq.size() < DEPTH);
        exp_iv  = !c_rst && (mq.size() != 0);
        check("req_valid", 32'(imem_req_valid), 32'(exp_req));
        if (exp_req) check("req_addr", imem_req_addr, m_pc);
        check("instr_valid", 32'(instr_valid), 32'(exp_iv));
        if (!c_rst) begin
            if (mq.size() != 0) begin
                head = mq[0];
                check("instr", instr, head[31:0]);
                check("instr_pc", instr_pc, head[63:32]);
            end else begin
                check("empty_instr", instr, NOP);
                check("empty_pc", instr_pc, 32'h0);
            end
        end

        fire = exp_req && imem_req_ready;
        pop  = exp_iv && instr_ready && !c_redir;
        if (c_rst) begin
            mq.delete();
            m_pc  = RST_PC;
            m_out = 0;
        end else if (c_redir) begin
            mq.delete();
            m_pc = {c_rpc[31:2], 2'b00};
            if (m_out) begin
                if (rsp) m_out = 0;
                else     m_stale = 1;
            end
        end else begin
            if (pop) void'(mq.pop_front());
            if (m_out && rsp) begin
                if (!m_stale) mq.push_back({m_out_pc, imem_rsp_data});
                m_out = 0;
            end
            if (fire) begin
                m_out    = 1;
                m_stale  = 0;
                m_out_pc = m_pc;
                m_pc     = m_pc + 32'd4;
            end
        end

        if (rsp) mem_busy = 0;
        else if (mem_busy) mem_cnt--;
        if (imem_req_valid && imem_req_ready) begin
            mem_busy = 1;
            mem_addr = imem_req_addr;
            mem_cnt  = $urandom_range(c_lat_max - 1);
        end
    endtask

    initial begin
        int last_pop;
        int npop;
        bit hit;

        // Reset and 1-cycle memory streaming
        c_rst = 1; cycle(); cycle();
        c_rst = 0; c_rdy_pct = 100; c_mem_pct = 100; c_lat_max = 1;
        cycle();
        check("first_req_valid", 32'(obs_req_valid), 32'd1);
        check("first_req_addr", obs_addr, RST_PC);
        last_pop = -1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (obs_pop) begin
                if (last_pop >= 0) check("pop_gap", 32'(cyc - last_pop), 32'd2);
                last_pop = cyc;
            end
        end

        // Decode stall: buffer fills, fetch stops, then resumes in order
        c_rdy_pct = 0;
        for (int i = 0; i < 10; i++) cycle();
        check("stall_no_req", 32'(obs_req_valid), 32'd0);
        check("stall_valid", 32'(obs_iv), 32'd1);
        c_rdy_pct = 100;
        for (int i = 0; i < 12; i++) cycle();

        // Redirect while the 0x8 fetch is outstanding
        c_rst = 1; cycle(); c_rst = 0;
        c_lat_max = 3;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            cycle();
            hit = m_out && (m_out_pc == 32'h8);
        end
        check("reach_wait_0x8", 32'(hit), 32'd1);
        c_redir = 1; c_rpc = 32'h100; cycle(); c_redir = 0;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            cycle();
            hit = obs_req_valid;
        end
        check("redir_req_addr", obs_addr, 32'h100);
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            cycle();
            hit = obs_iv;
        end
        check("redir_first_pc", obs_pc, 32'h100);

        // Misaligned redirect colliding with a pop and a response
        c_rdy_pct = 0; c_lat_max = 2;
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            hit = mem_busy && (mem_cnt == 0) && m_out && !m_stale && (mq.size() != 0);
            if (!hit) cycle();
        end
        check("reach_collision", 32'(hit), 32'd1);
        c_redir = 1; c_rpc = 32'h103; c_rdy_pct = 100; cycle(); c_redir = 0;
        cycle();
        check("flush_empty", 32'(obs_iv), 32'd0);
        check("flush_req_valid", 32'(obs_req_valid), 32'd1);
        check("flush_req_addr", obs_addr, 32'h100);
        for (int i = 0; i < 10; i++) cycle();

        // Memory back-pressure at the top of the address space, then wrap
        c_lat_max = 1;
        c_redir = 1; c_rpc = 32'hFFFF_FFFC; c_mem_pct = 0; cycle(); c_redir = 0;
        for (int i = 0; i < 3; i++) cycle();
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("hold_valid", 32'(obs_req_valid), 32'd1);
            check("hold_addr", obs_addr, 32'hFFFF_FFFC);
        end
        c_mem_pct = 100;
        npop = 0;
        for (int i = 0; i < 30 && npop < 2; i++) begin
            cycle();
            if (obs_pop) begin
                check(npop == 0 ? "wrap_pc0" : "wrap_pc1", obs_pc,
                      npop == 0 ? 32'hFFFF_FFFC : 32'h0);
                npop++;
            end
        end
        check("wrap_pops", 32'(npop), 32'd2);

        // Reset while a fetch is outstanding; the late response must be ignored
        c_lat_max = 3;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            hit = m_out && mem_busy && (mem_cnt >= 1);
            if (!hit) cycle();
        end
        check("reach_wait_rst", 32'(hit), 32'd1);
        c_rst = 1; cycle(); c_rst = 0;
        cycle();
        check("post_rst_addr", obs_addr, RST_PC);
        check("post_rst_valid", 32'(obs_iv), 32'd0);
        for (int i = 0; i < 10; i++) cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            c_rdy_pct = 60;
            c_mem_pct = 70;
            c_lat_max = 1 + int'($urandom_range(2));
            c_redir   = ($urandom_range(99) < 5);
            c_rpc     = $urandom;
            c_rst     = ($urandom_range(199) == 0);
            cycle();
        end
        c_redir = 0; c_rst = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
